apb_initiator: RTL

//   APB requester: turns core-side load/store requests into APB SETUP/ACCESS transfers.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_initiator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM states and the latched request.
// Request fields are sized at the package widths; the initiator's width parameters must not exceed them.
package apb_pkg;

    localparam int APB_STB_W  = 4;
    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic                  write;
        logic [APB_STB_W-1:0]  stb;
    } apb_req_t;

endpackage

// File: rtl/apb_initiator.sv
// APB requester: one core request becomes one SETUP/ACCESS transfer and one response.
// A watchdog aborts ACCESS phases that wait too long for pready.
module apb_initiator
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = APB_ADDR_W,
    parameter int DATA_WIDTH = APB_DATA_W,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  req_write,
    input  logic [APB_STB_W-1:0]  req_stb,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [APB_STB_W-1:0]  pstb,
    input  logic                  pready,
    input  logic                  perr
);

    localparam int CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int TLIM = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TLIM);

    apb_state_e            state_q, state_d;
    apb_req_t              req_q, req_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  tmo_hit;

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == CNT_LIM) && !pready;

    // Next state, APB phase control, watchdog and response generation.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        req_ready   = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready || tmo_hit) begin
                    req_ready   = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pready ? perr : 1'b1;
                    if (pready && !perr && !req_q.write)
                        rsp_rdata_d = prdata;
                    state_d   = IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
        if (req_valid && req_ready) begin
            req_d.addr  = APB_ADDR_W'(req_addr);
            req_d.wdata = APB_DATA_W'(req_wdata);
            req_d.write = req_write;
            req_d.stb   = req_write ? req_stb : '0;
            state_d     = SETUP;
            psel_d      = 1'b1;
            penable_d   = 1'b0;
            cnt_d       = '0;
        end
    end

    // State and registered APB/response outputs; reset aborts any transfer.
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = req_q.write;
    assign pstb      = req_q.stb;
    assign paddr     = ADDR_WIDTH'(req_q.addr);
    assign pdata     = DATA_WIDTH'(req_q.wdata);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule
